// File: rtl/stage_2_decode.sv
// RV32I decode stage: field/immediate decode, register file read with bypass,
// load-use hazard detection and the registered decode/execute bundle.
module stage_2_decode #(
    parameter int          XLEN      = 32,
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_enable,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard_stall,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      funct3_out,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            alu_src_pc,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            branch,
    output logic            jump,
    output logic            illegal_out
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1v;
        logic [XLEN-1:0] rs2v;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [2:0]      f3;
        logic [3:0]      alu;
        logic            src_imm;
        logic            src_pc;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } bundle_t;

    logic [XLEN-1:0] regs [REG_COUNT];
    bundle_t         q;
    bundle_t         dec;
    bundle_t         bub;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            alt;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_rd;
    logic [XLEN-1:0] rs2_rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign opcode = instruction_in[6:0];
    assign f3     = instruction_in[14:12];
    assign rs1    = instruction_in[19:15];
    assign rs2    = instruction_in[24:20];
    assign alt    = instruction_in[30];

    assign imm_i = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:20]};
    assign imm_s = {{(XLEN-12){instruction_in[31]}}, instruction_in[31:25],
                    instruction_in[11:7]};
    assign imm_b = {{(XLEN-12){instruction_in[31]}}, instruction_in[7],
                    instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instruction_in[31]}}, instruction_in[30:12],
                    12'b0};
    assign imm_j = {{(XLEN-20){instruction_in[31]}}, instruction_in[19:12],
                    instruction_in[20], instruction_in[30:21], 1'b0};

    // Same-cycle writeback is forwarded so the bundle never sees stale data.
    assign rs1_rd = (rs1 == 5'd0) ? '0 :
                    (wb_enable && wb_rd == rs1) ? wb_data : regs[rs1];
    assign rs2_rd = (rs2 == 5'd0) ? '0 :
                    (wb_enable && wb_rd == rs2) ? wb_data : regs[rs2];

    function automatic logic [3:0] alu_sel(input logic [2:0] f,
                                           input logic       a,
                                           input logic       is_op);
        logic [3:0] r;
        case (f)
            3'b000:  r = (is_op && a) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = a ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        dec.valid = 1'b1;
        dec.pc    = pc_in;
        dec.rs1v  = rs1_rd;
        dec.rs2v  = rs2_rd;
        dec.rs1   = rs1;
        dec.rs2   = rs2;
        dec.rd    = instruction_in[11:7];
        dec.f3    = f3;
        unique case (opcode)
            OPC_LUI: begin
                uses_rs1      = 1'b0;
                dec.alu       = ALU_PASS;
                dec.imm       = imm_u;
                dec.src_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                uses_rs1      = 1'b0;
                dec.imm       = imm_u;
                dec.src_imm   = 1'b1;
                dec.src_pc    = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                uses_rs1      = 1'b0;
                dec.imm       = imm_j;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.imm       = imm_i;
                dec.src_imm   = 1'b1;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs2   = 1'b1;
                dec.imm    = imm_b;
                dec.alu    = ALU_SUB;
                dec.branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.imm       = imm_i;
                dec.src_imm   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                uses_rs2      = 1'b1;
                dec.imm       = imm_s;
                dec.src_imm   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                dec.imm       = imm_i;
                dec.src_imm   = 1'b1;
                dec.alu       = alu_sel(f3, alt, 1'b0);
                dec.reg_write = 1'b1;
            end
            OPC_OP: begin
                uses_rs2      = 1'b1;
                dec.alu       = alu_sel(f3, alt, 1'b1);
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Bubble carries the canonical NOP fields so rd stays x0.
    always_comb begin
        bub     = '0;
        bub.rd  = NOP_INSTR[11:7];
        bub.rs1 = NOP_INSTR[19:15];
        bub.f3  = NOP_INSTR[14:12];
    end

    assign hazard_stall = q.valid & q.mem_read & (q.rd != 5'd0)
                        & ((uses_rs1 & (rs1 == q.rd))
                         | (uses_rs2 & (rs2 == q.rd)))
                        & ~flush & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (wb_enable && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             q <= '0;
        else if (flush)        q <= bub;
        else if (stall)        q <= q;
        else if (hazard_stall) q <= bub;
        else                   q <= dec;
    end

    assign valid_out   = q.valid;
    assign pc_out      = q.pc;
    assign rs1_value   = q.rs1v;
    assign rs2_value   = q.rs2v;
    assign rs1_out     = q.rs1;
    assign rs2_out     = q.rs2;
    assign rd_out      = q.rd;
    assign imm_out     = q.imm;
    assign funct3_out  = q.f3;
    assign alu_op      = q.alu;
    assign alu_src_imm = q.src_imm;
    assign alu_src_pc  = q.src_pc;
    assign mem_read    = q.mem_read;
    assign mem_write   = q.mem_write;
    assign reg_write   = q.reg_write;
    assign branch      = q.branch;
    assign jump        = q.jump;
    assign illegal_out = q.illegal;

endmodule

// File: tb/tb_stage_2_decode.sv
// Bench for stage_2_decode: directed scenarios plus random instruction
// streams checked against an architectural model of the decode stage.
module tb_stage_2_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction_in = '0;
    logic [31:0] pc_in = '0;
    logic        wb_enable = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        hazard_stall;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [31:0] imm_out;
    logic [2:0]  funct3_out;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic        illegal_out;

    stage_2_decode dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .instruction_in(instruction_in), .pc_in(pc_in),
        .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .valid_out(valid_out),
        .pc_out(pc_out), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
        .imm_out(imm_out), .funct3_out(funct3_out), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .alu_src_pc(alu_src_pc),
        .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .branch(branch), .jump(jump),
        .illegal_out(illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        src_imm;
        logic        src_pc;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        br;
        logic        jp;
        logic        ill;
    } bund_t;

    // ALU code for each funct3; the alternate (instr[30]) form is the next code.
    localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4,
                                          4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [6:0] OPCS [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                        7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

    bund_t       e;
    logic [6:0]  e_opc;
    logic [31:0] mregs [32];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bund_t mdec(input logic [31:0] i,
                                   input logic [31:0] pc);
        bund_t b;
        b       = '0;
        b.valid = 1'b1;
        b.pc    = pc;
        b.rs1   = i[19:15];
        b.rs2   = i[24:20];
        b.rd    = i[11:7];
        b.f3    = i[14:12];
        case (i[6:0])
            7'h37: begin
                b.alu = 4'd10; b.imm = {i[31:12], 12'h000};
                b.src_imm = 1'b1; b.rw = 1'b1;
            end
            7'h17: begin
                b.imm = {i[31:12], 12'h000}; b.src_imm = 1'b1;
                b.src_pc = 1'b1; b.rw = 1'b1;
            end
            7'h6F: begin
                b.jp = 1'b1; b.rw = 1'b1;
                b.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            end
            7'h67: begin
                b.jp = 1'b1; b.rw = 1'b1; b.src_imm = 1'b1;
                b.imm = $signed(i[31:20]);
            end
            7'h63: begin
                b.br = 1'b1; b.alu = 4'd1;
                b.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            end
            7'h03: begin
                b.mr = 1'b1; b.rw = 1'b1; b.src_imm = 1'b1;
                b.imm = $signed(i[31:20]);
            end
            7'h23: begin
                b.mw = 1'b1; b.src_imm = 1'b1;
                b.imm = $signed({i[31:25], i[11:7]});
            end
            7'h13: begin
                b.rw = 1'b1; b.src_imm = 1'b1;
                b.imm = $signed(i[31:20]);
                b.alu = ALU_TAB[i[14:12]]
                      + 4'((i[14:12] == 3'd5) && i[30]);
            end
            7'h33: begin
                b.rw = 1'b1;
                b.alu = ALU_TAB[i[14:12]]
                      + 4'((i[14:12] == 3'd5 || i[14:12] == 3'd0) && i[30]);
            end
            default: b.ill = 1'b1;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r,
                                          input logic we,
                                          input logic [4:0] wr,
                                          input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return mregs[r];
    endfunction

    task automatic cmp();
        check("valid", valid_out, e.valid);
        check("ctl", {mem_read, mem_write, reg_write, branch, jump,
                      illegal_out}, {e.mr, e.mw, e.rw, e.br, e.jp, e.ill});
        check("rd", rd_out, e.rd);
        if (e.valid) begin
            check("pc", pc_out, e.pc);
            check("rs1", rs1_out, e.rs1);
            check("rs2", rs2_out, e.rs2);
            check("rs1v", rs1_value, e.rs1v);
            check("rs2v", rs2_value, e.rs2v);
            check("f3", funct3_out, e.f3);
            if (!e.ill && e_opc != 7'h33) check("imm", imm_out, e.imm);
            if (!e.ill && !e.jp) check("alu", alu_op, e.alu);
            if (e_opc inside {7'h13, 7'h33, 7'h17})
                check("src", {alu_src_imm, alu_src_pc},
                      {e.src_imm, e.src_pc});
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd,
                        output logic hz);
        logic [6:0] op;
        logic       u1;
        logic       u2;
        bund_t      n;
        @(negedge clk);
        instruction_in = ins;
        pc_in = pc;
        stall = st;
        flush = fl;
        wb_enable = we;
        wb_rd = wr;
        wb_data = wd;
        #1;
        op = ins[6:0];
        u1 = !(op inside {7'h37, 7'h17, 7'h6F});
        u2 = op inside {7'h33, 7'h23, 7'h63};
        hz = e.valid && e.mr && e.rd != 5'd0 && !fl && !st
           && ((u1 && ins[19:15] == e.rd) || (u2 && ins[24:20] == e.rd));
        check("hazard", hazard_stall, hz);
        if (fl || hz) begin
            e = '0;
            e_opc = '0;
        end else if (!st) begin
            n = mdec(ins, pc);
            n.rs1v = mread(ins[19:15], we, wr, wd);
            n.rs2v = mread(ins[24:20], we, wr, wd);
            e = n;
            e_opc = op;
        end
        if (we && wr != 5'd0) mregs[wr] = wd;
        @(posedge clk);
        #1;
        cmp();
    endtask

    initial begin
        logic        hz;
        logic        lh;
        logic [31:0] ins;
        logic [31:0] pc;
        e = '0;
        e_opc = '0;
        lh = 1'b0;
        ins = '0;
        pc = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_out, 1'b0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_rd", rd_out, 5'd0);
        check("rst_hz", hazard_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        step(32'h00500093, 32'h10, 0, 0, 0, 0, 0, hz);
        check("addi_valid", valid_out, 1'b1);
        check("addi_rd", rd_out, 5'd1);
        check("addi_imm", imm_out, 32'd5);
        check("addi_src", alu_src_imm, 1'b1);
        check("addi_rw", reg_write, 1'b1);
        check("addi_pc", pc_out, 32'h10);

        step(32'h00318233, 32'h14, 0, 0, 1, 5'd3, 32'hDEADBEEF, hz);
        check("byp_rs1", rs1_value, 32'hDEADBEEF);
        check("byp_rs2", rs2_value, 32'hDEADBEEF);
        step(32'h00000233, 32'h18, 0, 0, 1, 5'd0, 32'd7, hz);
        step(32'h00000233, 32'h1C, 0, 0, 0, 0, 0, hz);
        check("x0_zero", rs1_value, 32'd0);

        step(32'h0000A103, 32'h20, 0, 0, 0, 0, 0, hz);
        step(32'h002101B3, 32'h24, 0, 0, 0, 0, 0, hz);
        check("lu_hz", hz, 1'b1);
        check("lu_bubble", valid_out, 1'b0);
        step(32'h002101B3, 32'h24, 0, 0, 0, 0, 0, hz);
        check("lu_hz_drop", hazard_stall, 1'b0);
        check("lu_issue", valid_out, 1'b1);
        step(32'h0000A103, 32'h28, 0, 0, 0, 0, 0, hz);
        step(32'h002101B3, 32'h2C, 0, 1, 0, 0, 0, hz);
        check("fl_bubble", valid_out, 1'b0);

        step(32'h00500093, 32'h40, 0, 0, 0, 0, 0, hz);
        for (int k = 0; k < 3; k++)
            step($urandom, 32'h44 + 32'(4 * k), 1, 0, 0, 0, 0, hz);
        check("stall_pc", pc_out, 32'h40);
        step(32'h00500093, 32'h50, 1, 1, 0, 0, 0, hz);
        check("fl_st_bubble", valid_out, 1'b0);

        step(32'hFE000CE3, 32'h60, 0, 0, 0, 0, 0, hz);
        check("beq_imm", imm_out, 32'hFFFFFFF8);
        check("beq_br", branch, 1'b1);
        check("beq_alu", alu_op, 4'd1);
        step(32'h0000007F, 32'h64, 0, 0, 0, 0, 0, hz);
        check("ill_flag", illegal_out, 1'b1);
        check("ill_rw", reg_write, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            if (!lh) begin
                ins = $urandom;
                ins[6:0] = OPCS[$urandom_range(0, 9)];
                ins[11:7] = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                pc = pc + 32'd4;
            end
            step(ins, pc, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), $urandom, hz);
            lh = hz;
        end

        step(32'h00000013, 32'h200, 0, 0, 1, 5'd5, 32'd123, hz);
        step(32'h00900293, 32'h204, 0, 0, 0, 0, 0, hz);
        check("pre_rst_valid", valid_out, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", valid_out, 1'b0);
        check("arst_pc", pc_out, 32'd0);
        check("arst_rd", rd_out, 5'd0);
        check("arst_ctl", {mem_read, mem_write, reg_write, branch, jump,
                           illegal_out}, 6'd0);
        e = '0;
        e_opc = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        step(32'h00528333, 32'h300, 0, 0, 0, 0, 0, hz);
        check("x5_cleared", rs1_value, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_2_decode.md
Name: stage_2_decode

Overview:
- Second pipeline stage of the RV32I core, directly downstream of the fetch stage.
- Consumes the registered instruction and PC from fetch. Decodes control fields and immediates. Reads operands from an internal 32x32 register file, written by the writeback port.
- Produces a registered decode/execute bundle.
- Detects load-use hazards against the instruction it currently holds, and requests a fetch stall while inserting a bubble.

Parameters:
XLEN, 32, datapath and register width
REG_COUNT, 32, architectural registers; x0 hardwired to zero
NOP_INSTR, 32'h00000013, encoding treated as a bubble (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
stall  in  1  downstream stall; hold all output registers
flush  in  1  taken branch/jump resolved downstream; squash instruction_in
instruction_in  in  XLEN  instruction from fetch
pc_in  in  XLEN  PC of instruction_in
wb_enable  in  1  register file write enable
wb_rd  in  5  write index
wb_data  in  XLEN  write data
hazard_stall  out  1  combinational; fetch must hold its PC and output when high
valid_out  out  1  bundle holds a real instruction (0 = bubble)
pc_out  out  XLEN  PC of bundle
rs1_value, rs2_value  out  XLEN  operand values
rs1_out, rs2_out, rd_out  out  5 each  register indices
imm_out  out  XLEN  sign-extended immediate
funct3_out  out  3  raw funct3 (branch condition / memory size)
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
alu_src_imm, alu_src_pc  out  1 each  ALU B = imm / ALU A = pc
mem_read, mem_write, reg_write, branch, jump  out  1 each  control
illegal_out  out  1  unrecognised opcode

Behaviour:
- Reset (async, while high):
  - All output registers are 0, pc_out is 0, and rd_out is 0. The bundle is a bubble.
  - All register file entries clear to 0.
  - hazard_stall is 0.
- Latency: exactly 1 cycle from instruction_in to the bundle.
- Register update priority at each posedge, highest first:
  1. flush: load a bubble (valid_out=0, all control 0).
  2. stall: hold every output register.
  3. hazard_stall: load a bubble.
  4. Otherwise: load the decoded instruction_in.
- Bubble definition: valid_out=0; reg_write, mem_read, mem_write, branch, jump, illegal_out all 0. Data fields are don't-care, but a bench must see rd_out=0.
- instruction_in equal to NOP_INSTR decodes as an ordinary ADDI with reg_write=1 and rd=0. No special case.
- Load-use hazard:
  - hazard_stall = valid_out & mem_read & (rd_out!=0) & ((uses_rs1 & rs1==rd_out) | (uses_rs2 & rs2==rd_out)) & ~flush & ~stall.
  - uses_rs1: all formats except U and J. uses_rs2: R, S and B formats.
  - After the bubble is inserted, mem_read=0, so hazard_stall drops the next cycle. One bubble per load-use pair.
- Register file:
  - Write at posedge when wb_enable and wb_rd!=0. Writes to x0 are ignored.
  - Reads are combinational with write bypass: if wb_enable and wb_rd==rs and rs!=0, return wb_data. Index 0 always reads 0.
  - Writes proceed regardless of stall, flush or hazard.
- Decode (opcode[6:0]):
  - LUI: PASS_B, imm U, reg_write.
  - AUIPC: ADD, alu_src_pc, imm U, reg_write.
  - JAL: jump, imm J, reg_write. JALR: jump, imm I, reg_write.
  - BRANCH: branch, imm B, SUB.
  - LOAD: mem_read, ADD, imm I, reg_write.
  - STORE: mem_write, ADD, imm S.
  - OP-IMM: imm I, alu_src_imm, reg_write. SRAI is selected by instr[30].
  - OP: SUB/SRA selected by instr[30].
  - Any other opcode: valid_out=1, illegal_out=1, all write/mem controls 0.
- Immediates are sign-extended from instr[31]. B and J immediates have LSB 0. U immediate is instr[31:12]<<12.

Test Plan:
- Reset asserted mid-stream with valid_out=1 -> outputs zero immediately, before the next clock; x5 reads 0 afterwards.
- instruction_in=32'h00500093 (addi x1,x0,5), pc_in=32'h10 -> next cycle: valid_out=1, rd_out=1, imm_out=5, alu_src_imm=1, reg_write=1, pc_out=32'h10.
- Write x3=32'hDEADBEEF via wb in the same cycle as decoding add x4,x3,x3 -> rs1_value=rs2_value=32'hDEADBEEF (bypass). wb_rd=0 with wb_data=7 -> x0 still reads 0.
- lw x2,0(x1) followed by add x3,x2,x2 -> hazard_stall=1 for exactly one cycle, one bubble, then add issues with valid_out=1. Same with flush=1 -> hazard_stall=0 and a bubble is loaded.
- stall=1 for 3 cycles while instruction_in changes -> bundle unchanged. flush=1 and stall=1 together -> bubble loaded.
- beq with imm -8 -> imm_out=32'hFFFFFFF8, branch=1, alu_op=1. Opcode 7'h7F -> illegal_out=1, reg_write=0.
